// File: rtl/convolution_filter.sv
// ---------------------------------------------------------------------------
// convolution_filter
//
// Streaming 2-D convolution of a raster-scan grayscale frame with a runtime
// KERNEL_H x KERNEL_W signed kernel. Borders are zero-padded. Exactly one
// output pixel is produced per input pixel, in the same raster order.
//
// Architecture:
//   * KERNEL_H-1 circular line buffers, indexed by input column, hold the
//     previous lines.
//   * A KERNEL_H x KERNEL_W window register shifts left by one column per fed
//     position. The newest column is assembled from the line buffers and the
//     pixel being fed.
//   * The multiply-accumulate is combinational on the next window value and
//     loads a single output register.
//   * Padding is generated from the output row/column counters, so stale
//     line-buffer or window contents never reach the result.
//   * After the last input pixel of a frame, x_ready drops. The block then
//     feeds zero positions until every output of the frame has been emitted.
//     It then returns to idle with all counters at zero.
//
// Optional feature macro: CONV_ABS_OUTPUT_EN
//   defined   : the absolute value of the shifted sum is saturated, so
//               negative edge responses keep their magnitude.
//   undefined : negative sums saturate to 0.
//
// Ports:
//   clk      in   clock, all logic on the rising edge
//   rst      in   asynchronous active-high reset
//   x_valid  in   input pixel valid
//   x_ready  out  block can accept an input pixel
//   x_data   in   [W-1:0] unsigned input pixel
//   y_valid  out  output pixel valid; y_data is held stable until y_ready
//   y_ready  in   downstream accepts the output pixel
//   y_data   out  [W-1:0] unsigned output pixel
//   kernel   in   signed [W-1:0] [0:KERNEL_H-1][0:KERNEL_W-1] coefficients.
//                 kernel[i][j] weights the pixel at row offset i-KERNEL_H/2
//                 and column offset j-KERNEL_W/2. Held static during a frame.
// ---------------------------------------------------------------------------
module convolution_filter #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int KERNEL_H   = 3,
  parameter int KERNEL_W   = 3,
  parameter int W          = 8,
  parameter int W_FRAC     = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                x_valid,
  output logic                x_ready,
  input  logic [W-1:0]        x_data,
  output logic                y_valid,
  input  logic                y_ready,
  output logic [W-1:0]        y_data,
  input  logic signed [W-1:0] kernel [0:KERNEL_H-1][0:KERNEL_W-1]
);

  localparam int HALF_H  = KERNEL_H / 2;
  localparam int HALF_W  = KERNEL_W / 2;
  localparam int COL_W   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int OROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  // The feed row runs past the frame by up to HALF_H lines while flushing.
  localparam int FROW_W  = $clog2(IMG_HEIGHT + KERNEL_H);
  localparam int LB_ROWS = (KERNEL_H > 1) ? KERNEL_H - 1 : 1;
  localparam int AW      = 2 * W + $clog2(KERNEL_H * KERNEL_W) + 1;

  localparam logic [COL_W-1:0]     LAST_COL  = COL_W'(IMG_WIDTH - 1);
  localparam logic [OROW_W-1:0]    LAST_OROW = OROW_W'(IMG_HEIGHT - 1);
  localparam logic [FROW_W-1:0]    LAST_FROW = FROW_W'(IMG_HEIGHT - 1);
  localparam logic [FROW_W-1:0]    PRIME_ROW = FROW_W'(HALF_H);
  localparam logic [COL_W-1:0]     PRIME_COL = COL_W'(HALF_W);
  localparam logic signed [AW-1:0] PIX_MAX   = AW'((1 << W) - 1);

  // Control state
  logic              init_done;
  logic              flushing;
  logic [FROW_W-1:0] feed_row;
  logic [COL_W-1:0]  feed_col;
  logic [OROW_W-1:0] out_row;
  logic [COL_W-1:0]  out_col;

  // Datapath
  logic [W-1:0] win      [0:KERNEL_H-1][0:KERNEL_W-1];
  logic [W-1:0] next_win [0:KERNEL_H-1][0:KERNEL_W-1];
  logic [W-1:0] lb_out   [0:LB_ROWS-1];
  logic [W-1:0] feed_pix;

  logic in_fire;
  logic flush_fire;
  logic feed;
  logic primed;
  logic last_in;
  logic last_out;

  // MAC working variables
  int                     src_r;
  int                     src_c;
  logic signed [W:0]      pix_ext;
  logic signed [2*W:0]    prod;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   shifted;
  logic signed [AW-1:0]   mag;
  logic [W-1:0]           result;

  // Input is accepted only once out of reset, not while flushing, and only
  // when the output register is empty or is being drained this cycle.
  assign x_ready    = init_done && !flushing && (!y_valid || y_ready);
  assign in_fire    = x_valid && x_ready;
  assign flush_fire = flushing && (!y_valid || y_ready);
  assign feed       = in_fire || flush_fire;
  assign feed_pix   = flushing ? '0 : x_data;

  // An output becomes computable once the fed position has moved
  // HALF_H lines plus HALF_W pixels past it.
  assign primed   = (feed_row > PRIME_ROW) ||
                    ((feed_row == PRIME_ROW) && (feed_col >= PRIME_COL));
  assign last_in  = (feed_row == LAST_FROW) && (feed_col == LAST_COL);
  assign last_out = (out_row == LAST_OROW) && (out_col == LAST_COL);

  // Line buffers. line_buf[KERNEL_H-2] holds the previous line and
  // line_buf[0] the oldest. Each fed position pushes its column up one line.
  // Contents need no reset because padding comes from the counters.
  generate
    if (KERNEL_H > 1) begin : g_line_buf
      logic [W-1:0] line_buf [0:KERNEL_H-2][0:IMG_WIDTH-1];

      always_ff @(posedge clk) begin
        if (feed) begin
          for (int r = 0; r < KERNEL_H - 2; r++) begin
            line_buf[r][feed_col] <= line_buf[r+1][feed_col];
          end
          line_buf[KERNEL_H-2][feed_col] <= feed_pix;
        end
      end

      always_comb begin
        for (int r = 0; r < KERNEL_H - 1; r++) begin
          lb_out[r] = line_buf[r][feed_col];
        end
      end
    end else begin : g_no_line_buf
      always_comb begin
        lb_out[0] = '0;
      end
    end
  endgenerate

  // Next window: shift every row left by one column. Append the newest
  // column, which is made of the line-buffer column plus the fed pixel.
  // Entry [i][j] then holds the pixel at linear index
  // fed - (KERNEL_H-1-i)*IMG_WIDTH - (KERNEL_W-1-j).
  always_comb begin
    for (int i = 0; i < KERNEL_H; i++) begin
      for (int j = 0; j < KERNEL_W - 1; j++) begin
        next_win[i][j] = win[i][j+1];
      end
    end
    for (int i = 0; i < KERNEL_H - 1; i++) begin
      next_win[i][KERNEL_W-1] = lb_out[i];
    end
    next_win[KERNEL_H-1][KERNEL_W-1] = feed_pix;
  end

  // The window register holds only pixel data. Its validity is decided by
  // the padding mask, so it has no reset.
  always_ff @(posedge clk) begin
    if (feed) begin
      for (int i = 0; i < KERNEL_H; i++) begin
        for (int j = 0; j < KERNEL_W; j++) begin
          win[i][j] <= next_win[i][j];
        end
      end
    end
  end

  // Multiply-accumulate for the output at (out_row, out_col). Taps whose
  // source falls outside the frame contribute zero. This masking also stops
  // columns from wrapping across lines.
  always_comb begin
    acc     = '0;
    src_r   = 0;
    src_c   = 0;
    pix_ext = '0;
    prod    = '0;
    for (int i = 0; i < KERNEL_H; i++) begin
      for (int j = 0; j < KERNEL_W; j++) begin
        src_r = int'(out_row) + i - HALF_H;
        src_c = int'(out_col) + j - HALF_W;
        if ((src_r >= 0) && (src_r < IMG_HEIGHT) &&
            (src_c >= 0) && (src_c < IMG_WIDTH)) begin
          pix_ext = {1'b0, next_win[i][j]};
          prod    = pix_ext * kernel[i][j];
          acc     = acc + AW'(prod);
        end
      end
    end
  end

  // Scale by the coefficient fraction, optionally fold negatives, then
  // clamp into the unsigned pixel range.
  always_comb begin
    shifted = acc >>> W_FRAC;
`ifdef CONV_ABS_OUTPUT_EN
    mag = (shifted < 0) ? -shifted : shifted;
`else
    mag = shifted;
`endif
    if (mag < 0) begin
      result = '0;
    end else if (mag > PIX_MAX) begin
      result = '1;
    end else begin
      result = mag[W-1:0];
    end
  end

  // Sequencing:
  //   * Every fed position advances the feed counters.
  //   * Once primed, each fed position also loads one output and advances
  //     the output counters.
  //   * The last output of the frame returns everything to idle.
  //   * Accepting the last input of the frame starts the zero-fed flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_done <= 1'b0;
      flushing  <= 1'b0;
      feed_row  <= '0;
      feed_col  <= '0;
      out_row   <= '0;
      out_col   <= '0;
      y_valid   <= 1'b0;
      y_data    <= '0;
    end else begin
      init_done <= 1'b1;
      if (feed) begin
        if (primed) begin
          y_valid <= 1'b1;
          y_data  <= result;
        end else begin
          y_valid <= 1'b0;
        end

        if (primed && last_out) begin
          flushing <= 1'b0;
          feed_row <= '0;
          feed_col <= '0;
          out_row  <= '0;
          out_col  <= '0;
        end else begin
          if (feed_col == LAST_COL) begin
            feed_col <= '0;
            feed_row <= feed_row + 1'b1;
          end else begin
            feed_col <= feed_col + 1'b1;
          end

          if (primed) begin
            if (out_col == LAST_COL) begin
              out_col <= '0;
              out_row <= out_row + 1'b1;
            end else begin
              out_col <= out_col + 1'b1;
            end
          end

          if (in_fire && last_in) begin
            flushing <= 1'b1;
          end
        end
      end else if (y_ready) begin
        y_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_convolution_filter.sv
// ---------------------------------------------------------------------------
// tb_convolution_filter
//
// Scoreboard bench for convolution_filter on an 8x6 frame with a 3x3 kernel.
// When each frame's stimulus is issued, its expected output stream is pushed
// into a queue. A separate monitor pops and compares every accepted output.
// Expected streams come from hand-derived rules (identity, sharpen, box,
// edge) or from a direct zero-padded convolution model.
// ---------------------------------------------------------------------------
module tb_convolution_filter;

  localparam int IW   = 8;
  localparam int IH   = 6;
  localparam int NPIX = IW * IH;

  logic              clk     = 1'b0;
  logic              rst     = 1'b0;
  logic              x_valid = 1'b0;
  logic              x_ready;
  logic [7:0]        x_data  = 8'd0;
  logic              y_valid;
  logic              y_ready = 1'b1;
  logic [7:0]        y_data;
  logic signed [7:0] kernel [0:2][0:2];

  logic [7:0] frame [0:NPIX-1];
  logic [7:0] exp_q [$];

  int checks     = 0;
  int errors     = 0;
  int out_count  = 0;
  bit rand_ready = 1'b0;

  convolution_filter #(
    .IMG_WIDTH (IW),
    .IMG_HEIGHT(IH),
    .KERNEL_H  (3),
    .KERNEL_W  (3),
    .W         (8),
    .W_FRAC    (0)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .x_valid(x_valid),
    .x_ready(x_ready),
    .x_data (x_data),
    .y_valid(y_valid),
    .y_ready(y_ready),
    .y_data (y_data),
    .kernel (kernel)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Downstream ready: always high, or a 50% random pattern.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      y_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: a handshake seen at the falling edge completes at the next
  // rising edge, because the bench only drives inputs just after rising edges.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && y_valid && y_ready) begin
        out_count++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got %0d, expected no output", y_data);
        end else begin
          checkOutput($sformatf("pixel_%0d", out_count - 1), int'(y_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic setKernel(input int k00, input int k01, input int k02,
                           input int k10, input int k11, input int k12,
                           input int k20, input int k21, input int k22);
    kernel[0][0] = 8'(k00); kernel[0][1] = 8'(k01); kernel[0][2] = 8'(k02);
    kernel[1][0] = 8'(k10); kernel[1][1] = 8'(k11); kernel[1][2] = 8'(k12);
    kernel[2][0] = 8'(k20); kernel[2][1] = 8'(k21); kernel[2][2] = 8'(k22);
  endtask

  // Hand-derived expected values for the directed frames.
  function automatic int handExpected(input int t, input int r, input int c);
    bit border;
    bit corner;
    border = (r == 0) || (r == IH - 1) || (c == 0) || (c == IW - 1);
    corner = ((r == 0) || (r == IH - 1)) && ((c == 0) || (c == IW - 1));
    case (t)
      1: return r * IW + c;
      2: return corner ? 255 : (border ? 200 : 100);
      3: return corner ? 40 : (border ? 60 : 90);
      default: begin
        if (border) return 255;
`ifdef CONV_ABS_OUTPUT_EN
        if ((r == 3) && (c == 3)) return 255;
`else
        if ((r == 3) && (c == 3)) return 0;
`endif
        if ((r >= 2) && (r <= 4) && (c >= 2) && (c <= 4)) return 100;
        return 0;
      end
    endcase
  endfunction

  // Direct zero-padded convolution of the current frame and kernel.
  function automatic int refPixel(input int r, input int c);
    int acc;
    int sr;
    int sc;
    acc = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        sr = r + i - 1;
        sc = c + j - 1;
        if ((sr >= 0) && (sr < IH) && (sc >= 0) && (sc < IW)) begin
          acc += int'(frame[sr * IW + sc]) * int'(kernel[i][j]);
        end
      end
    end
`ifdef CONV_ABS_OUTPUT_EN
    if (acc < 0) acc = -acc;
`endif
    if (acc < 0) return 0;
    if (acc > 255) return 255;
    return acc;
  endfunction

  task automatic pushHand(input int t);
    for (int k = 0; k < NPIX; k++) exp_q.push_back(8'(handExpected(t, k / IW, k % IW)));
  endtask

  task automatic pushModel();
    for (int k = 0; k < NPIX; k++) exp_q.push_back(8'(refPixel(k / IW, k % IW)));
  endtask

  // Drives the first n pixels of frame[], with optional random x_valid gaps.
  // It returns just after the rising edge that accepted the last pixel.
  task automatic applyStimulus(input int n, input bit gaps, input bit check_latency);
    bit accepted;
    int wait_cycles;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          x_valid = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      x_valid     = 1'b1;
      x_data      = frame[i];
      accepted    = 1'b0;
      wait_cycles = 0;
      while (!accepted) begin
        @(negedge clk);
        accepted = x_ready;
        @(posedge clk);
        #1;
        wait_cycles++;
        if (!accepted && (wait_cycles > 500)) begin
          checks++;
          errors++;
          $display("[TB] FAIL input_timeout: got no accept for pixel %0d, expected accept", i);
          x_valid = 1'b0;
          return;
        end
      end
      if (check_latency && (i == 8)) checkOutput("latency_before_first", int'(y_valid), 0);
      if (check_latency && (i == 9)) checkOutput("latency_first", int'(y_valid), 1);
    end
    x_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name, input int expected_count);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < 3000)) begin
      @(posedge clk);
      n++;
    end
    checkOutput({name, "_drained"}, exp_q.size(), 0);
    repeat (30) @(posedge clk);
    #1;
    checkOutput({name, "_count"}, out_count, expected_count);
  endtask

  task automatic pulseReset(input int cycles, input string tag);
    rst = 1'b1;
    #1;
    exp_q.delete();
    checkOutput({tag, "_y_valid"}, int'(y_valid), 0);
    checkOutput({tag, "_x_ready"}, int'(x_ready), 0);
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checkOutput({tag, "_x_ready_held"}, int'(x_ready), 0);
    @(posedge clk);
    #1;
    checkOutput({tag, "_x_ready_up"}, int'(x_ready), 1);
  endtask

  initial begin
    setKernel(0, 0, 0, 0, 1, 0, 0, 0, 0);
    #2;
    pulseReset(3, "reset");

    // Identity kernel on a ramp, with the first-output latency check.
    $display("[TB] identity kernel");
    for (int i = 0; i < NPIX; i++) frame[i] = 8'(i);
    out_count = 0;
    pushHand(1);
    applyStimulus(NPIX, 1'b0, 1'b1);
    waitDrain("identity", NPIX);

    // Sharpen kernel on a constant frame.
    $display("[TB] sharpen kernel");
    setKernel(0, -1, 0, -1, 5, -1, 0, -1, 0);
    for (int i = 0; i < NPIX; i++) frame[i] = 8'd100;
    out_count = 0;
    pushHand(2);
    applyStimulus(NPIX, 1'b0, 1'b0);
    waitDrain("sharpen", NPIX);

    // Box kernel on a constant frame.
    $display("[TB] box kernel");
    setKernel(1, 1, 1, 1, 1, 1, 1, 1, 1);
    for (int i = 0; i < NPIX; i++) frame[i] = 8'd10;
    out_count = 0;
    pushHand(3);
    applyStimulus(NPIX, 1'b0, 1'b0);
    waitDrain("box", NPIX);

    // Edge kernel with a single dark pixel at (3,3).
    $display("[TB] edge kernel");
    setKernel(-1, -1, -1, -1, 8, -1, -1, -1, -1);
    for (int i = 0; i < NPIX; i++) frame[i] = 8'd100;
    frame[3 * IW + 3] = 8'd0;
    out_count = 0;
    pushHand(4);
    applyStimulus(NPIX, 1'b0, 1'b0);
    waitDrain("edge", NPIX);

    // Two back-to-back frames with random backpressure and input gaps.
    $display("[TB] backpressure frames");
    setKernel(1, 2, 1, 0, 0, 0, -1, -2, -1);
    rand_ready = 1'b1;
    out_count  = 0;
    for (int i = 0; i < NPIX; i++) frame[i] = 8'((i * 37 + 11) % 256);
    pushModel();
    applyStimulus(NPIX, 1'b1, 1'b0);
    for (int i = 0; i < NPIX; i++) frame[i] = 8'((i * i * 3 + 5) % 256);
    pushModel();
    applyStimulus(NPIX, 1'b1, 1'b0);
    waitDrain("backpressure", 2 * NPIX);
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset after 20 inputs abandons the frame. A fresh frame then follows.
    $display("[TB] mid-frame reset");
    setKernel(1, 1, 1, 1, 2, 1, 1, 1, 1);
    for (int i = 0; i < NPIX; i++) frame[i] = 8'((i * 5) % 256);
    out_count = 0;
    pushModel();
    applyStimulus(20, 1'b0, 1'b0);
    pulseReset(1, "midreset");
    out_count = 0;
    for (int i = 0; i < NPIX; i++) frame[i] = 8'((i * 13 + 7) % 256);
    pushModel();
    applyStimulus(NPIX, 1'b0, 1'b0);
    waitDrain("after_reset", NPIX);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
